// File: rtl/axis_elastic_buffer.sv
// AXI-Stream style elastic FIFO with fully registered outputs.
// The head beat is kept in a register (m_data/m_last) and also remains in the circular store.
module axis_elastic_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic                       m_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_next;
  logic [PW-1:0]   rd_next;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;

  always_comb begin
    push       = s_valid && s_ready;
    pop        = m_valid && m_ready;
    wr_next    = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    rd_next    = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push && !pop)
      count_next = count + ONE_C;
    else if (pop && !push)
      count_next = count - ONE_C;
  end

  // Storage array carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rstn && !flush && push)
      mem[wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      almost_full <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
    end else begin
      count       <= count_next;
      s_ready     <= (count_next < DEPTH_C);
      m_valid     <= (count_next != '0);
      almost_full <= (count_next >= AF_C);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_next;
        if (pop)
          rd_ptr <= rd_next;
        // Head register reloads only when the head beat changes; a beat arriving
        // as the last stored one leaves bypasses the array.
        if (pop && count > ONE_C)
          {m_last, m_data} <= mem[rd_next];
        else if (push && (count == '0 || (pop && count == ONE_C)))
          {m_last, m_data} <= {s_last, s_data};
      end
    end
  end

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Randomised and directed bench for axis_elastic_buffer, checked against a queue model.
// Unit 0 uses DEPTH=4, unit 1 uses DEPTH=3; both run every cycle and are always checked.
module tb_axis_elastic_buffer;

  logic       clk = 1'b0;
  logic       rstn     [2];
  logic       flush    [2];
  logic       s_valid  [2];
  logic       s_ready  [2];
  logic [7:0] s_data   [2];
  logic       s_last   [2];
  logic       m_valid  [2];
  logic       m_ready  [2];
  logic [7:0] m_data   [2];
  logic       m_last   [2];
  logic       almost_full [2];
  logic [2:0] count4;
  logic [1:0] count3;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: one queue of {last,data} per unit plus expected flags.
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  bit         expReady [2];
  bit         expValid [2];
  logic [7:0] expData  [2];
  bit         expLast  [2];
  int         depthOf  [2];
  int         afOf     [2];

  always #5 clk = ~clk;

  axis_elastic_buffer #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn[0]), .flush(flush[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .count(count4), .almost_full(almost_full[0])
  );

  axis_elastic_buffer #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .rstn(rstn[1]), .flush(flush[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .count(count3), .almost_full(almost_full[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int qSize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic stepModel(input int u);
    bit doPush;
    bit doPop;
    logic [8:0] head;
    if (!rstn[u]) begin
      if (u == 0) q0.delete(); else q1.delete();
      expReady[u] = 1'b0;
      expValid[u] = 1'b0;
      expData[u]  = 8'h00;
      expLast[u]  = 1'b0;
      return;
    end
    if (flush[u]) begin
      if (u == 0) q0.delete(); else q1.delete();
    end else begin
      doPush = s_valid[u] && expReady[u];
      doPop  = expValid[u] && m_ready[u];
      if (u == 0) begin
        if (doPop)  void'(q0.pop_front());
        if (doPush) q0.push_back({s_last[u], s_data[u]});
      end else begin
        if (doPop)  void'(q1.pop_front());
        if (doPush) q1.push_back({s_last[u], s_data[u]});
      end
    end
    expReady[u] = qSize(u) < depthOf[u];
    expValid[u] = qSize(u) != 0;
    if (qSize(u) != 0) begin
      head = (u == 0) ? q0[0] : q1[0];
      expData[u] = head[7:0];
      expLast[u] = head[8];
    end
  endtask

  task automatic checkUnit(input int u, input bit afterReset);
    logic [31:0] cnt;
    cnt = (u == 0) ? 32'(count4) : 32'(count3);
    checkOutput($sformatf("u%0d s_ready", u), 32'(s_ready[u]), 32'(expReady[u]));
    checkOutput($sformatf("u%0d m_valid", u), 32'(m_valid[u]), 32'(expValid[u]));
    checkOutput($sformatf("u%0d count", u), cnt, 32'(qSize(u)));
    checkOutput($sformatf("u%0d almost_full", u), 32'(almost_full[u]),
                32'(rstn[u] && qSize(u) >= afOf[u]));
    if (expValid[u] || afterReset) begin
      checkOutput($sformatf("u%0d m_data", u), 32'(m_data[u]), 32'(expData[u]));
      checkOutput($sformatf("u%0d m_last", u), 32'(m_last[u]), 32'(expLast[u]));
    end
  endtask

  task automatic tick();
    bit wasReset [2];
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      wasReset[u] = !rstn[u];
      stepModel(u);
    end
    #1;
    for (int u = 0; u < 2; u++) checkUnit(u, wasReset[u]);
  endtask

  task automatic applyStimulus(input int u, input bit sv, input logic [7:0] d, input bit sl,
                               input bit mr, input bit fl, input bit rn);
    s_valid[u] = sv;
    s_data[u]  = d;
    s_last[u]  = sl;
    m_ready[u] = mr;
    flush[u]   = fl;
    rstn[u]    = rn;
    tick();
  endtask

  task automatic idle(input int u, input int n, input bit mr);
    for (int i = 0; i < n; i++) applyStimulus(u, 1'b0, 8'h00, 1'b0, mr, 1'b0, 1'b1);
  endtask

  initial begin
    int beat;
    logic [7:0] pat [4];
    depthOf[0] = 4; afOf[0] = 3;
    depthOf[1] = 3; afOf[1] = 2;
    for (int u = 0; u < 2; u++) begin
      rstn[u] = 1'b0; flush[u] = 1'b0; s_valid[u] = 1'b0;
      s_data[u] = 8'h00; s_last[u] = 1'b0; m_ready[u] = 1'b0;
      expReady[u] = 1'b0; expValid[u] = 1'b0; expData[u] = 8'h00; expLast[u] = 1'b0;
    end
    #2;
    tick();
    tick();
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    tick();

    // Fill with downstream stalled, then drain in order.
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, pat[i], 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(0, 5, 1'b1);

    // Back-to-back streaming.
    for (int i = 1; i <= 20; i++) applyStimulus(0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b1);
    idle(0, 3, 1'b1);

    // Flush colliding with a push and a pop.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 8'h6F, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(0, 4, 1'b1);

    // Reset mid-stream, then a fresh beat is the first delivered.
    for (int i = 0; i < 2; i++) applyStimulus(0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(0, 1, 1'b0);
    applyStimulus(0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(0, 3, 1'b1);

    // Wrap test on the DEPTH=3 unit with random stalls; beat 5 carries s_last.
    beat = 0;
    for (int c = 0; c < 300 && beat < 10; c++) begin
      bit accepted;
      accepted = expReady[1];
      applyStimulus(1, 1'b1, 8'(8'hB0 + beat), beat == 4, ($urandom % 3) == 0, 1'b0, 1'b1);
      if (accepted) beat++;
    end
    checkOutput("u1 wrap beats pushed", 32'(beat), 32'd10);
    idle(1, 12, 1'b1);

    // Random traffic on both units with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      int u;
      u = i % 2;
      applyStimulus(u, 1'($urandom % 2), 8'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0,
                    ($urandom % 40) == 0, ($urandom % 60) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/axis_elastic_buffer.md
AXIS_ELASTIC_BUFFER -- requirements
Module: axis_elastic_buffer

Interface
REQ-001 Parameter WIDTH, default 8, payload bits per beat.
REQ-002 Parameter DEPTH, default 4, storage entries; legal range 2..256; need not be a power of two.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, occupancy at which almost_full asserts; legal range 1..DEPTH.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all stored beats.
REQ-007 s_valid  input  1  upstream beat valid.
REQ-008 s_ready  output  1  buffer can accept; registered.
REQ-009 s_data  input  WIDTH  upstream payload.
REQ-010 s_last  input  1  upstream end-of-packet marker.
REQ-011 m_valid  output  1  downstream beat valid; registered.
REQ-012 m_ready  input  1  downstream accepts.
REQ-013 m_data  output  WIDTH  downstream payload; registered.
REQ-014 m_last  output  1  end-of-packet marker travelling with m_data.
REQ-015 count  output  $clog2(DEPTH+1)  beats held, including the one presented on m_data.
REQ-016 almost_full  output  1  count >= AF_LEVEL; registered.

Function
REQ-017 Push = s_valid && s_ready; pop = m_valid && m_ready; both sampled at the same rising edge.
REQ-018 count_next = count + push - pop; simultaneous push and pop leaves count unchanged.
REQ-019 All outputs (s_ready, m_valid, m_data, m_last, count, almost_full) are registered and derive from count_next, with no combinational path from any input to any output.
REQ-020 s_ready = (count_next < DEPTH); m_valid = (count_next != 0); almost_full = (count_next >= AF_LEVEL).
REQ-021 Latency: a beat pushed into an empty buffer at edge k is valid on m_data/m_last after edge k.
REQ-022 Throughput: sustained one beat per cycle when s_valid and m_ready are held high, with no bubbles.
REQ-023 Ordering is strict FIFO; s_data and s_last of one beat always emerge together.
REQ-024 Storage is circular, with a write pointer and a read pointer; each pointer wraps from DEPTH-1 to 0.
REQ-025 m_data updates only when the head beat changes: on a pop, or on a push into an empty buffer; otherwise it holds even when m_ready is low.
REQ-026 Full boundary: at count = DEPTH, s_ready = 0; a pop at that edge raises s_ready after the edge.
REQ-027 Empty boundary: at count = 1 with pop and no push, m_valid = 0 after the edge.
REQ-028 Flush: at an edge with flush = 1, count becomes 0, both pointers become 0, m_valid = 0, s_ready = 1, and almost_full = 0.
REQ-029 A push or pop coinciding with flush is discarded.
REQ-030 m_data/m_last hold their last value after a flush or drain and are don't-care while m_valid = 0.

Reset
REQ-031 While rstn = 0 at a rising edge, all state clears: count = 0, pointers = 0, m_valid = 0, s_ready = 0, almost_full = 0, m_data = 0, m_last = 0.
REQ-032 After the first edge with rstn = 1, s_ready = 1.
REQ-033 Reset mid-operation discards all stored beats, and rstn has priority over flush.

Verification
REQ-034 Fill/drain (DEPTH=4, WIDTH=8): push 0x11,0x22,0x33,0x44 with m_ready = 0 -> count = 4, s_ready = 0, almost_full = 1 after the third push; then m_ready = 1 -> 0x11..0x44 emerge in order, and m_valid = 0 after the fourth pop.
REQ-035 Streaming: s_valid = m_ready = 1 for 20 cycles with an incrementing payload -> 20 beats delivered back-to-back, count constant at 1, payload 1-cycle delayed.
REQ-036 Wrap: DEPTH=3, 10 beats with randomised m_ready stalls -> beats delivered in order with no loss or duplication; s_last = 1 on beat 5 emerges as m_last = 1 on beat 5 only.
REQ-037 Flush collision: count = 3, then assert flush with s_valid = 1 and m_ready = 1 -> next cycle count = 0, m_valid = 0, s_ready = 1, and neither beat is delivered later.
REQ-038 Reset mid-stream: count = 2, then rstn = 0 for one edge -> all outputs at reset values, s_ready = 1 one edge after release, and the next pushed beat 0xA5 is the first delivered.
